// File: rtl/fir_mc_cu_if.sv
// Handshake and datapath-strobe bundle for the multi-channel FIR control unit.
// The master modport is the controller; the slave modport is its environment.
interface fir_mc_cu_if #(
    parameter int SEL_W = 8,
    parameter int CH_W  = 1
);
    logic             input_valid;
    logic [CH_W-1:0]  input_channel;
    logic [SEL_W-1:0] taps_cfg;
    logic             input_ready;
    logic             load_input;
    logic             clear_acc;
    logic             mac_enable;
    logic [SEL_W-1:0] coef_sel;
    logic [CH_W-1:0]  channel_sel;
    logic             output_valid;
    logic [CH_W-1:0]  output_channel;
    logic             output_ready;
    logic             shift_enable;
    logic             busy;
    logic             err_channel;

    modport master (
        input  input_valid, input_channel, taps_cfg, output_ready,
        output input_ready, load_input, clear_acc, mac_enable, coef_sel,
               channel_sel, output_valid, output_channel, shift_enable,
               busy, err_channel
    );

    modport slave (
        output input_valid, input_channel, taps_cfg, output_ready,
        input  input_ready, load_input, clear_acc, mac_enable, coef_sel,
               channel_sel, output_valid, output_channel, shift_enable,
               busy, err_channel
    );
endinterface

// File: rtl/fir_mc_cu.sv
// Sequencer for a time-multiplexed single-MAC FIR: accepts a tagged sample, runs
// taps_lat MAC cycles on its channel, then holds the result until it is taken.
module fir_mc_cu #(
    parameter int MAX_TAPS = 8,
    parameter int SEL_W    = 8,
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,   // asynchronous, active-low
    fir_mc_cu_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_CALC, S_OUT} state_t;

    // Tap count needs one extra bit: MAX_TAPS may equal 2^SEL_W.
    localparam logic [SEL_W:0] TAPS_MAX = (SEL_W+1)'(MAX_TAPS);
    localparam logic [SEL_W:0] TAPS_ONE = (SEL_W+1)'(1);
    localparam logic [CH_W:0]  CH_LIM   = (CH_W+1)'(CHANNELS);

    state_t           r_state;
    state_t           w_next_state;
    logic [SEL_W-1:0] r_coef_sel;
    logic [CH_W-1:0]  r_channel_sel;
    logic [SEL_W:0]   r_taps_lat;
    logic             r_err_channel;
    logic             w_ch_ok;
    logic             w_accept;
    logic             w_reject;
    logic             w_last;

    function automatic logic [SEL_W:0] clamp_taps(input logic [SEL_W-1:0] cfg);
        logic [SEL_W:0] ext;
        ext = {1'b0, cfg};
        if (ext == '0 || ext > TAPS_MAX)
            return TAPS_MAX;
        return ext;
    endfunction

    assign w_ch_ok  = ({1'b0, bus.input_channel} < CH_LIM);
    assign w_accept = (r_state == S_IDLE) && bus.input_valid && w_ch_ok;
    assign w_reject = (r_state == S_IDLE) && bus.input_valid && !w_ch_ok;
    assign w_last   = ({1'b0, r_coef_sel} == (r_taps_lat - TAPS_ONE));

    always_comb begin
        w_next_state     = r_state;
        bus.input_ready  = 1'b0;
        bus.load_input   = 1'b0;
        bus.clear_acc    = 1'b0;
        bus.mac_enable   = 1'b0;
        bus.output_valid = 1'b0;
        bus.shift_enable = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.input_ready = 1'b1;
                if (w_accept) begin
                    bus.load_input = 1'b1;
                    w_next_state   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.clear_acc = 1'b1;
                w_next_state  = S_CALC;
            end
            S_CALC: begin
                bus.mac_enable = 1'b1;
                if (w_last)
                    w_next_state = S_OUT;
            end
            S_OUT: begin
                bus.output_valid = 1'b1;
                if (bus.output_ready) begin
                    bus.shift_enable = 1'b1;
                    w_next_state     = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_coef_sel    <= '0;
            r_channel_sel <= '0;
            r_taps_lat    <= TAPS_MAX;
            r_err_channel <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_channel_sel <= bus.input_channel;
                r_taps_lat    <= clamp_taps(bus.taps_cfg);
            end
            if (w_reject)
                r_err_channel <= 1'b1;
            // Counter parks on the last tap in CALC and returns to 0 on leaving OUT.
            case (r_state)
                S_CLEAR: r_coef_sel <= '0;
                S_CALC:  if (!w_last) r_coef_sel <= r_coef_sel + SEL_W'(1);
                S_OUT:   if (bus.output_ready) r_coef_sel <= '0;
                default: ;
            endcase
        end
    end

    assign bus.coef_sel       = r_coef_sel;
    assign bus.channel_sel    = r_channel_sel;
    assign bus.output_channel = r_channel_sel;
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.err_channel    = r_err_channel;
endmodule
